// File: rtl/rf_pkg.sv
// Shared constants and payload type for the register-file writeback arbiter.
package rf_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned NREG    = 1 << ADDR_W;
  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_LD  = 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot: accepts a request when empty or being
// granted, and tracks whether its entry arrived after the other slot's entry.
module wb_slot
  import rf_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_valid,
  input  wb_req_t i_req,
  input  logic    i_grant,
  input  logic    i_other_full,
  input  logic    i_other_grant,
  output logic    o_ready,
  output logic    o_full,
  output logic    o_age,
  output wb_req_t o_req
);

  logic    r_full;
  logic    r_age;
  wb_req_t r_req;
  logic    w_ready;
  logic    w_load;

  assign w_ready = !rst && (!r_full || i_grant);
  assign w_load  = i_valid && w_ready;

  // The other slot is older only if it keeps its entry through this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_age  <= 1'b0;
      r_req  <= '0;
    end else if (w_load) begin
      r_full <= 1'b1;
      r_age  <= i_other_full && !i_other_grant;
      r_req  <= i_req;
    end else if (i_grant) begin
      r_full <= 1'b0;
      r_age  <= 1'b0;
    end else if (i_other_grant) begin
      r_age  <= 1'b0;
    end
  end

  assign o_ready = w_ready;
  assign o_full  = r_full;
  assign o_age   = r_age;
  assign o_req   = r_req;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port between ALU and load writeback using
// oldest-first arbitration, and publishes a pending-write mask for decode.
module rf_write_arbiter
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREG-1:0]   pending_mask,
  output logic              busy
);

  logic [1:0]        w_full;
  logic [1:0]        w_age;
  logic [1:0]        w_grant;
  wb_req_t           w_req [2];
  wb_req_t           w_s0_req;
  wb_req_t           w_s1_req;
  wb_req_t           w_sel;
  logic [NREG-1:0]   w_mask;
  logic              r_rf_write;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  assign w_s0_req = '{addr: s0_addr, data: s0_data};
  assign w_s1_req = '{addr: s1_addr, data: s1_data};

  wb_slot u_slot_alu (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (s0_valid),
    .i_req         (w_s0_req),
    .i_grant       (w_grant[SRC_ALU]),
    .i_other_full  (w_full[SRC_LD]),
    .i_other_grant (w_grant[SRC_LD]),
    .o_ready       (s0_ready),
    .o_full        (w_full[SRC_ALU]),
    .o_age         (w_age[SRC_ALU]),
    .o_req         (w_req[SRC_ALU])
  );

  wb_slot u_slot_ld (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (s1_valid),
    .i_req         (w_s1_req),
    .i_grant       (w_grant[SRC_LD]),
    .i_other_full  (w_full[SRC_ALU]),
    .i_other_grant (w_grant[SRC_ALU]),
    .o_ready       (s1_ready),
    .o_full        (w_full[SRC_LD]),
    .o_age         (w_age[SRC_LD]),
    .o_req         (w_req[SRC_LD])
  );

  // Oldest entry wins; simultaneous arrivals go to ALU so the load lands last.
  always_comb begin
    w_grant = '0;
    if (w_full[SRC_ALU] && (!w_full[SRC_LD] || !w_age[SRC_ALU])) begin
      w_grant[SRC_ALU] = 1'b1;
    end else if (w_full[SRC_LD]) begin
      w_grant[SRC_LD] = 1'b1;
    end
  end

  assign w_sel = w_grant[SRC_LD] ? w_req[SRC_LD] : w_req[SRC_ALU];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf_write <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_rf_write <= |w_grant;
      if (|w_grant) begin
        r_waddr <= w_sel.addr;
        r_wdata <= w_sel.data;
      end
    end
  end

  always_comb begin
    w_mask = '0;
    for (int unsigned a = 0; a < NREG; a++) begin
      w_mask[a] = (w_full[SRC_ALU] && (w_req[SRC_ALU].addr == ADDR_W'(a))) ||
                  (w_full[SRC_LD]  && (w_req[SRC_LD].addr  == ADDR_W'(a))) ||
                  (r_rf_write      && (r_waddr             == ADDR_W'(a)));
    end
  end

  assign rf_write     = r_rf_write;
  assign rf_waddr     = r_waddr;
  assign rf_wdata     = r_wdata;
  assign pending_mask = w_mask;
  assign busy         = (|w_full) || r_rf_write;

endmodule
